sd_data_xfer_ctrl: RTL

Sequencer for the SD data serial engine. It accepts read/write transfer requests from the register bank, waits for the command phase to complete, and for writes waits for TX FIFO data. It then issues the one-cycle start code (01 write, 10 read, 11 abort), tracks completion through the engine's busy/crc_ok outputs, enforces a data timeout, and raises status pulses for the interrupt logic. It sits in the sd_clk domain, between the command master/register bank and the serial data host.

---
 rtl/sd_data_xfer_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_data_xfer_ctrl.sv
// Data-phase sequencer for the SD serial data engine: waits for command and FIFO
// readiness, issues start/abort codes, supervises completion and timeout.
module sd_data_xfer_ctrl #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst_n,
  input  logic                 req_tx,
  input  logic                 req_rx,
  input  logic                 cmd_done,
  input  logic                 cmd_err,
  input  logic                 abort,
  input  logic [TIMEOUT_W-1:0] timeout_val,
  input  logic                 tx_fifo_empty,
  input  logic                 rx_fifo_ovf,
  input  logic                 dat_busy,
  input  logic                 dat_crc_ok,
  output logic [1:0]           start_dat,
  output logic                 fifo_rst,
  output logic                 xfer_active,
  output logic                 done_int,
  output logic                 crc_err_int,
  output logic                 timeout_int,
  output logic                 fifo_err_int,
  output logic                 cmd_fail_int
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CMD  = 3'd1,
    S_WAIT_FIFO = 3'd2,
    S_START     = 3'd3,
    S_RUN       = 3'd4,
    S_ABORT     = 3'd5,
    S_FLUSH     = 3'd6
  } state_t;

  localparam logic [1:0]           CODE_NONE  = 2'b00;
  localparam logic [1:0]           CODE_WRITE = 2'b01;
  localparam logic [1:0]           CODE_READ  = 2'b10;
  localparam logic [1:0]           CODE_ABORT = 2'b11;
  localparam logic [TIMEOUT_W-1:0] TIMER_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] TIMER_ZERO = TIMEOUT_W'(0);

  state_t               state_q;
  logic                 dir_wr_q;
  logic                 busy_seen_q;
  logic                 hold_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic [1:0]           start_dat_q;
  logic                 fifo_rst_q;
  logic                 xfer_active_q;
  logic                 done_q;
  logic                 crc_err_q;
  logic                 timeout_q;
  logic                 fifo_err_q;
  logic                 cmd_fail_q;

  logic timer_en_s;
  logic timer_hit_s;
  logic run_done_s;

  assign timer_en_s  = (timeout_val != TIMER_ZERO);
  assign timer_hit_s = timer_en_s && (timer_q == TIMER_ONE);
  assign run_done_s  = busy_seen_q && !dat_busy;

  // Single sequencing process: state, counters and every registered output.
  always_ff @(posedge sd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dir_wr_q      <= 1'b0;
      busy_seen_q   <= 1'b0;
      hold_q        <= 1'b0;
      timer_q       <= TIMER_ZERO;
      start_dat_q   <= CODE_NONE;
      fifo_rst_q    <= 1'b0;
      xfer_active_q <= 1'b0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_q     <= 1'b0;
      fifo_err_q    <= 1'b0;
      cmd_fail_q    <= 1'b0;
    end else begin
      fifo_rst_q <= 1'b0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      fifo_err_q <= 1'b0;
      cmd_fail_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_tx || req_rx) begin
            dir_wr_q      <= req_tx;
            state_q       <= S_WAIT_CMD;
            xfer_active_q <= 1'b1;
          end
        end
        S_WAIT_CMD: begin
          if (abort) begin
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b0;
          end else if (cmd_err) begin
            cmd_fail_q <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= S_FLUSH;
          end else if (cmd_done) begin
            if (dir_wr_q) begin
              state_q <= S_WAIT_FIFO;
            end else begin
              state_q     <= S_START;
              start_dat_q <= CODE_READ;
            end
          end
        end
        S_WAIT_FIFO: begin
          if (abort) begin
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b0;
          end else if (!tx_fifo_empty) begin
            state_q     <= S_START;
            start_dat_q <= CODE_WRITE;
          end
        end
        S_START: begin
          // The engine may not have raised busy yet, so the abort code is held an extra cycle.
          if (abort) begin
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b1;
          end else begin
            state_q     <= S_RUN;
            start_dat_q <= CODE_NONE;
            timer_q     <= timeout_val;
            busy_seen_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b0;
          end else if (timer_hit_s) begin
            timeout_q   <= 1'b1;
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b0;
          end else if (!dir_wr_q && rx_fifo_ovf) begin
            fifo_err_q  <= 1'b1;
            state_q     <= S_ABORT;
            start_dat_q <= CODE_ABORT;
            hold_q      <= 1'b0;
          end else if (run_done_s) begin
            done_q        <= 1'b1;
            crc_err_q     <= !dat_crc_ok;
            state_q       <= S_IDLE;
            xfer_active_q <= 1'b0;
          end else begin
            if (dat_busy) begin
              busy_seen_q <= 1'b1;
            end
            // Saturate at 1 so a stale zero count can never wrap.
            if (timer_en_s && (timer_q > TIMER_ONE)) begin
              timer_q <= timer_q - TIMER_ONE;
            end
          end
        end
        S_ABORT: begin
          if (hold_q) begin
            hold_q <= 1'b0;
          end else if (!dat_busy) begin
            start_dat_q <= CODE_NONE;
            done_q      <= 1'b1;
            state_q     <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          fifo_rst_q    <= 1'b1;
          state_q       <= S_IDLE;
          xfer_active_q <= 1'b0;
        end
        default: begin
          state_q       <= S_IDLE;
          start_dat_q   <= CODE_NONE;
          xfer_active_q <= 1'b0;
          hold_q        <= 1'b0;
        end
      endcase
    end
  end

  assign start_dat    = start_dat_q;
  assign fifo_rst     = fifo_rst_q;
  assign xfer_active  = xfer_active_q;
  assign done_int     = done_q;
  assign crc_err_int  = crc_err_q;
  assign timeout_int  = timeout_q;
  assign fifo_err_int = fifo_err_q;
  assign cmd_fail_int = cmd_fail_q;

endmodule
